// File: rtl/divmod.sv
// divmod: 20-bit by 8-bit restoring divider producing one quotient bit per cycle.
// Signed (truncating) division is compiled in by defining DIVMOD_SIGNED_EN.
module divmod #(
    parameter int unsigned NoConfigBits = 2
) (
    input  logic                    UserCLK,
    input  logic                    clr_n,
    input  logic                    start,
    input  logic                    N19, N18, N17, N16, N15, N14, N13, N12, N11, N10,
    input  logic                    N9, N8, N7, N6, N5, N4, N3, N2, N1, N0,
    input  logic                    D7, D6, D5, D4, D3, D2, D1, D0,
    input  logic [NoConfigBits-1:0] ConfigBits,
    output logic                    Q19, Q18, Q17, Q16, Q15, Q14, Q13, Q12, Q11, Q10,
    output logic                    Q9, Q8, Q7, Q6, Q5, Q4, Q3, Q2, Q1, Q0,
    output logic                    R7, R6, R5, R4, R3, R2, R1, R0,
    output logic                    busy,
    output logic                    done,
    output logic                    dz
);

    localparam int unsigned NW = 20;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 5;

`ifdef DIVMOD_SIGNED_EN
    typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t state, state_next;

    logic [NW-1:0] n_in, n_op, q_sh, q_step, q_reg;
    logic [DW-1:0] d_in, d_op, dvs, rem, rem_step, r_reg;
    logic [DW:0]   part_rem;
    logic [CW-1:0] cnt;
    logic          busy_reg, done_reg, dz_reg;
    logic          accept_c, sticky_c, dzero_c, last_c, unused_cfg;

    assign n_in = {N19, N18, N17, N16, N15, N14, N13, N12, N11, N10,
                   N9, N8, N7, N6, N5, N4, N3, N2, N1, N0};
    assign d_in = {D7, D6, D5, D4, D3, D2, D1, D0};

    assign sticky_c   = ConfigBits[1];
    assign unused_cfg = ^ConfigBits;
    assign accept_c   = start && (state == IDLE || state == DONE);
    assign dzero_c    = (d_in == '0);
    assign last_c     = (cnt == CW'(NW - 1));

`ifdef DIVMOD_SIGNED_EN
    logic signed_c, signed_op, neg_q, neg_r;

    // Signed mode divides magnitudes; 0x80000 and 0x80 stay representable as unsigned.
    assign signed_c = ConfigBits[0];
    assign n_op = (signed_c && n_in[NW-1]) ? -n_in : n_in;
    assign d_op = (signed_c && d_in[DW-1]) ? -d_in : d_in;
`else
    assign n_op = n_in;
    assign d_op = d_in;
`endif

    // One restoring step: shift the next dividend bit into the 9-bit partial remainder.
    always_comb begin
        part_rem = {rem, q_sh[NW-1]};
        rem_step = part_rem[DW-1:0];
        q_step   = {q_sh[NW-2:0], 1'b0};
        if (part_rem >= {1'b0, dvs}) begin
            rem_step  = DW'(part_rem - {1'b0, dvs});
            q_step[0] = 1'b1;
        end
    end

    always_ff @(posedge UserCLK) begin
        if (!clr_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_c) state_next = dzero_c ? DONE : RUN;
            end
            RUN: begin
`ifdef DIVMOD_SIGNED_EN
                if (last_c) state_next = signed_op ? FIXUP : DONE;
`else
                if (last_c) state_next = DONE;
`endif
            end
`ifdef DIVMOD_SIGNED_EN
            FIXUP: state_next = DONE;
`endif
            DONE: begin
                if (accept_c)      state_next = dzero_c ? DONE : RUN;
                else if (!sticky_c) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered status outputs.
    always_ff @(posedge UserCLK) begin
        if (!clr_n) begin
            cnt      <= '0;
            q_sh     <= '0;
            rem      <= '0;
            dvs      <= '0;
            q_reg    <= '0;
            r_reg    <= '0;
            dz_reg   <= 1'b0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
`ifdef DIVMOD_SIGNED_EN
            signed_op <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
`ifdef DIVMOD_SIGNED_EN
            busy_reg <= (state_next == RUN) || (state_next == FIXUP);
`else
            busy_reg <= (state_next == RUN);
`endif
            done_reg <= (state_next == DONE);
            if (accept_c) begin
                cnt    <= '0;
                q_sh   <= n_op;
                dvs    <= d_op;
                rem    <= '0;
                dz_reg <= dzero_c;
                if (dzero_c) begin
                    q_reg <= '1;
                    r_reg <= n_in[DW-1:0];
                end
`ifdef DIVMOD_SIGNED_EN
                signed_op <= signed_c;
                neg_q     <= signed_c && (n_in[NW-1] ^ d_in[DW-1]);
                neg_r     <= signed_c && n_in[NW-1];
`endif
            end else if (state == RUN) begin
                cnt  <= last_c ? '0 : cnt + CW'(1);
                q_sh <= q_step;
                rem  <= rem_step;
`ifdef DIVMOD_SIGNED_EN
                if (last_c && !signed_op) begin
`else
                if (last_c) begin
`endif
                    q_reg <= q_step;
                    r_reg <= rem_step;
                end
`ifdef DIVMOD_SIGNED_EN
            end else if (state == FIXUP) begin
                q_reg <= neg_q ? -q_sh : q_sh;
                r_reg <= neg_r ? -rem : rem;
`endif
            end
        end
    end

    assign {Q19, Q18, Q17, Q16, Q15, Q14, Q13, Q12, Q11, Q10,
            Q9, Q8, Q7, Q6, Q5, Q4, Q3, Q2, Q1, Q0} = q_reg;
    assign {R7, R6, R5, R4, R3, R2, R1, R0} = r_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign dz   = dz_reg;

endmodule
